// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file and its clear engine.
// The optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [1:0] {
    CLEAR_IDLE  = 2'd0,
    CLEAR_SWEEP = 2'd1,
    CLEAR_DONE  = 2'd2
  } clear_state_t;

  localparam int XLEN_DEF     = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int PC_W_DEF     = 8;
  localparam int LINK_REG_DEF = 31;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks entries 1..DEPTH-1 one per cycle and
// reports progress through clear_busy and a one-cycle clear_done pulse.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clear_state_t  state, state_next;
  logic [AW-1:0] idx, idx_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Entry 0 is never stored, so the sweep starts at 1 and stops at the last index.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      CLEAR_IDLE: begin
        if (clear_req) begin
          state_next = CLEAR_SWEEP;
          idx_next   = AW'(1);
        end
      end
      CLEAR_SWEEP: begin
        if (idx == LAST_IDX) state_next = CLEAR_DONE;
        else                 idx_next   = idx + AW'(1);
      end
      CLEAR_DONE: state_next = CLEAR_IDLE;
      default:    state_next = CLEAR_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR_SWEEP);
    clear_done = (state == CLEAR_DONE);
    clr_we     = (state == CLEAR_SWEEP);
    clr_addr   = idx;
  end

endmodule

// File: rtl/regfile_param.sv
// Multi-port register file: NUM_RD async reads, data + link write ports, sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes onto the read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   link_en,
  input  logic [PC_W-1:0]        link_data,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done
);

  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            link_acc;
  logic            data_acc;
  logic [XLEN-1:0] link_ext;

  logic [XLEN-1:0] mem     [1:DEPTH-1];
  logic [XLEN-1:0] rf_view [DEPTH];
  logic            ent_we  [1:DEPTH-1];
  logic [XLEN-1:0] ent_wd  [1:DEPTH-1];

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  assign link_ext = XLEN'(link_data);

  // Priority: sweep clear, then link port, then data port; callers stall on clear_busy.
  always_comb begin
    link_acc = link_en && !clear_busy;
    data_acc = wr_en && !clear_busy && (wr_addr != '0) &&
               !(link_acc && (wr_addr == LINK_ADDR));
    for (int i = 1; i < DEPTH; i++) begin
      ent_we[i] = 1'b0;
      ent_wd[i] = '0;
      if (clr_we && (clr_addr == AW'(i))) begin
        ent_we[i] = 1'b1;
      end else if (link_acc && (i == LINK_REG)) begin
        ent_we[i] = 1'b1;
        ent_wd[i] = link_ext;
      end else if (data_acc && (wr_addr == AW'(i))) begin
        ent_we[i] = 1'b1;
        ent_wd[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (ent_we[i]) mem[i] <= ent_wd[i];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) rf_view[i] = mem[i];
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*XLEN +: XLEN] = rf_view[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Accepted writes never target entry 0, so address 0 can never be forwarded.
      if (link_acc && (rd_addr[k*AW +: AW] == LINK_ADDR))
        rd_data[k*XLEN +: XLEN] = link_ext;
      else if (data_acc && (rd_addr[k*AW +: AW] == wr_addr))
        rd_data[k*XLEN +: XLEN] = wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param at default parameters; expected read values
// come from a reference array updated as writes are driven.
module tb_regfile_param;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int PC_W   = 8;
  localparam int AW     = 5;
  localparam int LINK   = 31;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   link_en;
  logic [PC_W-1:0]        link_data;
  logic                   clear_req;
  logic                   clear_busy;
  logic                   clear_done;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] ref_mem [DEPTH];
  string           tag_q  [$];
  int              port_q [$];
  logic [XLEN-1:0] exp_q  [$];

  regfile_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .link_en    (link_en),
    .link_data  (link_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic rd_push(input string tag, input int port, input int addr, input logic [31:0] exp);
    rd_addr[port*AW +: AW] = AW'(addr);
    tag_q.push_back(tag);
    port_q.push_back(port);
    exp_q.push_back(exp);
  endtask

  task automatic rd_drain();
    string           t;
    int              p;
    logic [XLEN-1:0] e;
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      p = port_q.pop_front();
      e = exp_q.pop_front();
      check(t, rd_data[p*XLEN +: XLEN], e);
    end
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_push(tag, 0, a, ref_mem[a]);
      rd_push(tag, 1, a + 1, ref_mem[a+1]);
      rd_drain();
      tick();
    end
  endtask

  task automatic do_write(input logic we, input int wa, input logic [31:0] wd,
                          input logic le, input logic [7:0] ld);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    link_en   = le;
    link_data = ld;
    tick();
    wr_en   = 1'b0;
    link_en = 1'b0;
    if (le) ref_mem[LINK] = {24'h0, ld};
    if (we && (wa != 0) && !(le && (wa == LINK))) ref_mem[wa] = wd;
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int done_cnt;
    logic [31:0] byp_exp;

    rst_n     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    link_en   = 1'b0;
    link_data = '0;
    clear_req = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset after writes, with writes still asserted during the reset edge
    do_write(1'b1, 4, 32'hCAFEF00D, 1'b0, 8'h00);
    do_write(1'b1, 31, 32'h00005555, 1'b0, 8'h00);
    rst_n     = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 5'd6;
    wr_data   = 32'h00000066;
    link_en   = 1'b1;
    link_data = 8'h77;
    tick();
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    link_en = 1'b0;
    model_reset();
    check("rst_busy", {31'b0, clear_busy}, 32'd0);
    check("rst_done", {31'b0, clear_done}, 32'd0);
    read_all("rst_rd");

    // Basic data write and hardwired zero
    do_write(1'b1, 5, 32'hDEADBEEF, 1'b0, 8'h00);
    rd_push("wr5", 0, 5, 32'hDEADBEEF);
    rd_drain();
    do_write(1'b1, 0, 32'hFFFFFFFF, 1'b0, 8'h00);
    rd_push("wr0", 1, 0, 32'h00000000);
    rd_drain();

    // Link port priority and dual write
    do_write(1'b1, 31, 32'h00001234, 1'b1, 8'h44);
    rd_push("link_prio", 0, 31, 32'h00000044);
    rd_drain();
    do_write(1'b1, 31, 32'h0000BEEF, 1'b0, 8'h00);
    do_write(1'b1, 7, 32'h00001234, 1'b1, 8'h44);
    rd_push("link_r31", 0, 31, 32'h00000044);
    rd_push("link_r7", 1, 7, 32'h00001234);
    rd_drain();

    // Random mix of data and link writes
    for (int n = 0; n < 24; n++)
      do_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom(),
               ($urandom_range(0, 3) == 0), 8'($urandom()));
    read_all("rand_rd");

    // Same-cycle read of a register being written
    do_write(1'b1, 9, 32'h11111111, 1'b0, 8'h00);
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = 32'h11111111;
`endif
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hA5A5A5A5;
    rd_push("byp_same", 0, 9, byp_exp);
    rd_push("byp_zero", 1, 0, 32'h00000000);
    rd_drain();
    tick();
    wr_en = 1'b0;
    ref_mem[9] = 32'hA5A5A5A5;
    rd_push("byp_next", 0, 9, 32'hA5A5A5A5);
    rd_drain();

    // Full clear sweep with a dropped write in the middle
    for (int a = 1; a < DEPTH; a++) do_write(1'b1, a, 32'(a), 1'b0, 8'h00);
    read_all("fill_rd");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cnt  = 0;
    done_at   = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h00000033;
        link_en = 1'b1;
        link_data = 8'h99;
      end else begin
        wr_en   = 1'b0;
        link_en = 1'b0;
      end
      if (clear_busy) busy_cnt++;
      if (clear_done) begin
        done_at = c;
        break;
      end
      tick();
    end
    wr_en   = 1'b0;
    link_en = 1'b0;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_done_cycle", 32'(done_at), 32'd32);
    tick();
    check("clr_done_pulse", {31'b0, clear_done}, 32'd0);
    check("clr_busy_after", {31'b0, clear_busy}, 32'd0);
    model_reset();
    read_all("clr_rd");

    // Reset in the middle of a sweep aborts without a done pulse
    for (int a = 1; a < DEPTH; a += 3) do_write(1'b1, a, 32'hF0F00000 | 32'(a), 1'b0, 8'h00);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    check("abort_busy_pre", {31'b0, clear_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("abort_busy", {31'b0, clear_busy}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (clear_done || clear_busy) done_cnt++;
      tick();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    read_all("abort_rd");
    do_write(1'b1, 12, 32'h0BADCAFE, 1'b0, 8'h00);
    rd_push("post_abort_wr", 1, 12, 32'h0BADCAFE);
    rd_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
